// File: rtl/sram_like_resp.sv
// rtl/sram_like_resp.sv - SRAM-like bus responder: word RAM behind an in-order fixed-latency response FIFO
// Optional SRAM_RESP_RAND_DELAY_EN adds LFSR-driven addr_ok gating and 0..3 extra response cycles.
module sram_like_resp #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DEPTH      = 2,
  parameter int          RESP_LAT   = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int TW_BASE = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
`ifdef SRAM_RESP_RAND_DELAY_EN
  localparam int TW      = TW_BASE + 2;
`else
  localparam int TW      = TW_BASE;
`endif

  logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
  logic                  r_is_wr [DEPTH];
  logic [31:0]           r_rdata [DEPTH];
  logic [TW-1:0]         r_timer [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_push;
  logic                  w_pop;
  logic [TW-1:0]         w_push_timer;
  logic                  w_unused;

  assign w_idx    = data_sram_addr[ADDR_WIDTH+1:2];
  assign w_unused = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign data_sram_addr_ok = (r_count < CW'(DEPTH)) && !r_lfsr[0];
  assign w_push_timer      = TW'(RESP_LAT - 1) + TW'(r_lfsr[3:2]);
`else
  assign data_sram_addr_ok = (r_count < CW'(DEPTH));
  assign w_push_timer      = TW'(RESP_LAT - 1);
`endif

  assign w_push            = data_sram_req && data_sram_addr_ok && !reset;
  assign data_sram_data_ok = (r_count != '0) && (r_timer[r_rd_ptr] == '0);
  assign w_pop             = data_sram_data_ok;
  assign data_sram_rdata   = (data_sram_data_ok && !r_is_wr[r_rd_ptr]) ? r_rdata[r_rd_ptr] : 32'h0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // RAM survives reset; a write is durable once its address handshake completes.
  always_ff @(posedge clk) begin
    if (w_push && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_timer[i] <= '0;
        r_is_wr[i] <= 1'b0;
        r_rdata[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_timer[i] != '0) r_timer[i] <= r_timer[i] - 1'b1;
      end
      // Read data is snapshotted here, so later writes cannot disturb a queued read.
      if (w_push) begin
        r_timer[r_wr_ptr] <= w_push_timer;
        r_is_wr[r_wr_ptr] <= data_sram_wr;
        r_rdata[r_wr_ptr] <= data_sram_wr ? 32'h0 : r_mem[w_idx];
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
